// File: rtl/pad_event_pkg.sv
// Shared constants for the pad event queue: event kinds, button indices, scan FSM states.
package pad_event_pkg;

   localparam int unsigned EVT_W = 5;

   localparam logic [1:0] KIND_PRESS   = 2'd0;
   localparam logic [1:0] KIND_RELEASE = 2'd1;
   localparam logic [1:0] KIND_REPEAT  = 2'd2;

   localparam logic [2:0] BTN_START  = 3'd0;
   localparam logic [2:0] BTN_SELECT = 3'd1;
   localparam logic [2:0] BTN_B      = 3'd2;
   localparam logic [2:0] BTN_A      = 3'd3;
   localparam logic [2:0] BTN_DOWN   = 3'd4;
   localparam logic [2:0] BTN_UP     = 3'd5;
   localparam logic [2:0] BTN_RIGHT  = 3'd6;
   localparam logic [2:0] BTN_LEFT   = 3'd7;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_e;

   function automatic logic [EVT_W-1:0] make_evt(input logic [1:0] kind, input logic [2:0] idx);
      return {kind, idx};
   endfunction

endpackage

// File: rtl/pad_event_fifo.sv
// Synchronous FIFO; pointers carry one extra bit so full and empty are distinguishable.
module pad_event_fifo #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             pop_en;
   logic             push_en;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign pop_en  = pop && !empty;
   assign push_en = push && (!full || pop_en);

   assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_en) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_en) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push_en) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/pad_event_queue.sv
// Debounces the controller button vector and turns changes into press/release/repeat
// events buffered in a FIFO drained over a valid/ready handshake.
module pad_event_queue
   import pad_event_pkg::*;
#(
   parameter logic [15:0] STABLE_CNT   = 16'd27000,
   parameter logic [23:0] REPEAT_DELAY = 24'd13500000,
   parameter logic [23:0] REPEAT_RATE  = 24'd2700000,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [7:0]       plyr_input,
   output logic [7:0]       held,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [EVT_W-1:0] evt_data,
   output logic             overflow
);

   logic [7:0]       s1_q, s2_q;
   logic [15:0]      stable_cnt_q, stable_cnt_d;
   logic [7:0]       held_q, held_d;
   logic [7:0]       diff_q, diff_d;
   scan_state_e      state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [23:0]      rep_cnt_q, rep_cnt_d;
   logic             push_q, push_d;
   logic [EVT_W-1:0] push_data_q, push_data_d;
   logic             overflow_q, overflow_d;

   logic             commit;
   logic             has_target;
   logic [2:0]       rep_target;
   logic             rep_fire;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;

   // s1 differing from s2 means s2 takes a new value at this edge.
   always_comb begin
      stable_cnt_d = stable_cnt_q;
      if (s1_q != s2_q) begin
         stable_cnt_d = '0;
      end else if (stable_cnt_q != STABLE_CNT) begin
         stable_cnt_d = stable_cnt_q + 16'd1;
      end
   end

   assign commit = (stable_cnt_q == STABLE_CNT) && (s2_q != held_q) && (state_q == IDLE);

   always_comb begin
      held_d = held_q;
      diff_d = diff_q;
      if (commit) begin
         held_d = s2_q;
         diff_d = s2_q ^ held_q;
      end
   end

   // Lowest held direction wins; iterate downward so the lowest index is assigned last.
   always_comb begin
      rep_target = BTN_DOWN;
      for (int i = 7; i >= 4; i--) begin
         if (held_q[i]) begin
            rep_target = 3'(i);
         end
      end
   end

   assign has_target = |held_q[7:4];

   // The counter saturates while scanning, so a due repeat fires once on the next IDLE cycle.
   assign rep_fire = has_target && (state_q == IDLE) && (rep_cnt_q >= REPEAT_DELAY - 24'd1);

   always_comb begin
      rep_cnt_d = rep_cnt_q;
      if (commit || !has_target) begin
         rep_cnt_d = '0;
      end else if (rep_fire) begin
         rep_cnt_d = REPEAT_DELAY - REPEAT_RATE;
      end else if (rep_cnt_q < REPEAT_DELAY) begin
         rep_cnt_d = rep_cnt_q + 24'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      push_d      = 1'b0;
      push_data_d = push_data_q;
      unique case (state_q)
         IDLE: begin
            if (commit) begin
               state_d = SCAN;
               idx_d   = 3'd0;
            end
            if (rep_fire) begin
               push_d      = 1'b1;
               push_data_d = make_evt(KIND_REPEAT, rep_target);
            end
         end
         SCAN: begin
            if (diff_q[idx_q]) begin
               push_d      = 1'b1;
               push_data_d = make_evt(held_q[idx_q] ? KIND_PRESS : KIND_RELEASE, idx_q);
            end
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign fifo_pop   = evt_valid && evt_ready;
   assign overflow_d = overflow_q | (push_q && fifo_full && !fifo_pop);

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_q         <= '0;
         s2_q         <= '0;
         stable_cnt_q <= '0;
         held_q       <= '0;
         diff_q       <= '0;
         state_q      <= IDLE;
         idx_q        <= '0;
         rep_cnt_q    <= '0;
         push_q       <= 1'b0;
         push_data_q  <= '0;
         overflow_q   <= 1'b0;
      end else begin
         s1_q         <= plyr_input;
         s2_q         <= s1_q;
         stable_cnt_q <= stable_cnt_d;
         held_q       <= held_d;
         diff_q       <= diff_d;
         state_q      <= state_d;
         idx_q        <= idx_d;
         rep_cnt_q    <= rep_cnt_d;
         push_q       <= push_d;
         push_data_q  <= push_data_d;
         overflow_q   <= overflow_d;
      end
   end

   pad_event_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push_q),
      .push_data (push_data_q),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (evt_data)
   );

   assign evt_valid = !fifo_empty;
   assign held      = held_q;
   assign overflow  = overflow_q;

endmodule
